chunked_serial_addsub: RTL and testbench
========================================

Name: chunked_serial_addsub

Overview:
- Multi-cycle, parametrised adder/subtractor; successor to the fixed 4-bit ripple-carry adder.
- Processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry through a register between cycles.
- Adds subtract mode, carry/borrow-in, status flags and valid/ready handshakes on input and output.
- Sits in the datapath wherever a narrow, low-area adder with flag reporting is needed.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH. Derived NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract (A - B).
- cin  input  1  carry-in for add, borrow-in for subtract.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- y  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  y == 0.

Behaviour:
- Interface: one clock (clk). Reset (reset) is synchronous and active-high.
- States: IDLE, RUN, DONE. A 2-bit state register plus a chunk counter of width clog2(NCHUNK), minimum 1 bit.
- Reset: the next state is IDLE; counter = 0; y = 0; cout = ovf = zero = 0; out_valid = 0; carry register = 0.
- Reset during RUN or DONE discards the in-flight operation; out_valid never rises for it.
- Handshake outputs: in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from registered state only.
- IDLE: on in_valid & in_ready, latch a, b_eff = sub ? ~b : b, and carry = cin ^ sub; clear counter; go to RUN. Otherwise stay in IDLE.
- Subtract semantics: sub=1, cin=0 gives A - B; sub=1, cin=1 gives A - B - 1.
- RUN, each cycle, with k = counter:
  - {c, s} = a[k*CHUNK +: CHUNK] + b_eff[k*CHUNK +: CHUNK] + carry.
  - Write s into y[k*CHUNK +: CHUNK] and set carry = c.
  - On k == NCHUNK-1, also register cout = c, ovf = (carry into MSB) ^ c, and zero = (final y == 0, including the chunk being written); then go to DONE. Otherwise counter++.
- Latency: accept at edge t; out_valid is high after edge t+NCHUNK. With NCHUNK = 1, that is one RUN cycle.
- DONE: y and flags hold stable while out_valid & !out_ready (backpressure of any length). On out_ready, go to IDLE; y and flags keep their value until overwritten by the next operation.
- Operand, sub and cin changes after acceptance are ignored. in_valid outside IDLE is ignored (no queuing).
- No overlap between operations: minimum issue interval is NCHUNK+2 cycles with out_ready held high.
- Partial y contents during RUN are undefined to consumers; only sample when out_valid = 1.
- All arithmetic is modulo 2^WIDTH; no X-propagation from unused paths.

Test Plan (WIDTH=16, CHUNK=4):
- Reset for 2 cycles -> in_ready=1, out_valid=0, y=0x0000, cout=ovf=zero=0.
- Add a=0x1234, b=0x0FFF, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; y=0x2233, cout=0, ovf=0, zero=0; in_ready returns 1 the cycle after the output handshake.
- Add a=0x7FFF, b=0x0001 -> y=0x8000, ovf=1, cout=0. Then add a=0xFFFF, b=0x0000, cin=1 -> y=0x0000, cout=1, zero=1, ovf=0.
- Sub a=0x0005, b=0x0005 -> y=0x0000, zero=1, cout=1, ovf=0. Then sub a=0x0000, b=0x0001 -> y=0xFFFF, cout=0, ovf=0. Then sub a=0x8000, b=0x0001 -> y=0x7FFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and changing a/b -> y, flags and out_valid stable, in_ready=0, and no new operation starts.
- Reset asserted after the 2nd RUN cycle, deasserted next cycle -> state is IDLE, out_valid stays 0. Then add a=0x0001, b=0x0001 -> y=0x0002 after 4 cycles.

Source files
------------

// File: rtl/chunked_serial_addsub.sv
// ---------------------------------------------------------------------------
// chunked_serial_addsub
//
// Multi-cycle adder/subtractor. It processes a WIDTH-bit operation CHUNK bits
// per clock and keeps the carry in a register between chunks. It also reports
// carry/borrow, signed overflow and zero. Valid/ready handshakes are provided
// on both the operand side and the result side. Only one operation is in
// flight at a time.
//
// WIDTH must be an integer multiple of CHUNK, and 1 <= CHUNK <= WIDTH.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   a, b, sub and cin are valid this cycle
//   in_ready   block can accept an operation (state == IDLE)
//   a, b       operands, WIDTH bits
//   sub        0 = A + B + cin, 1 = A - B - cin
//   cin        carry-in for add, borrow-in for subtract
//   out_valid  y and the flags are valid (state == DONE)
//   out_ready  consumer takes the result this cycle
//   y          result, modulo 2^WIDTH
//   cout       carry out of the MSB; for subtract, 1 = no borrow
//   ovf        signed two's-complement overflow
//   zero       y == 0
// ---------------------------------------------------------------------------
module chunked_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;        // holds b, or ~b when subtracting
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Datapath for the chunk selected by the counter.
    int               base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic             msb_cin;

    always_comb begin
        base    = int'(cnt_q) * CHUNK;
        a_chunk = a_q[base +: CHUNK];
        b_chunk = b_q[base +: CHUNK];
        sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // The carry into the top bit of the chunk is recovered from that
        // bit's sum. On the last chunk this is the carry into the word MSB.
        msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtract is A + ~B + 1. A borrow-in removes the +1.
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                y_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d            = sum[CHUNK];
                if (cnt_q == LAST_CHUNK) begin
                    cout_d  = sum[CHUNK];
                    ovf_d   = msb_cin ^ sum[CHUNK];
                    // y_d already holds the chunk being written this cycle.
                    zero_d  = (y_d == '0);
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // NOTE: the operand registers have no reset. Every operation loads them on accept, before RUN reads them.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_chunked_serial_addsub
//
// Bench for chunked_serial_addsub with WIDTH=16 and CHUNK=4.
// - The stimulus pushes one expected result per accepted operation.
// - A monitor pops and compares each result on the output handshake.
// - The monitor also checks that out_valid rises exactly NCHUNK cycles after
//   acceptance.
// - Expected values come from signed/unsigned integer arithmetic.
// ---------------------------------------------------------------------------
module tb_chunked_serial_addsub;

    localparam int W      = 16;
    localparam int C      = 4;
    localparam int NCHUNK = W / C;

    typedef struct {
        logic [W-1:0] y;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
    logic         zero;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ready_mode = 0;   // 0: hold 1, 1: hold 0, 2: random
    exp_t exp_q[$];

    chunked_serial_addsub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input logic mcin);
        exp_t   r;
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (!msub) begin
            ur     = ua + ub + longint'(mcin);
            sr     = sa + sb + longint'(mcin);
            r.cout = (ur >= (longint'(1) << W));
        end else begin
            ur     = ua - ub - longint'(mcin);
            sr     = sa - sb - longint'(mcin);
            r.cout = (ur >= 0);
        end
        r.y       = ur[W-1:0];
        r.ovf     = (sr < -(longint'(1) << (W - 1))) || (sr > (longint'(1) << (W - 1)) - 1);
        r.zero    = (r.y == '0);
        r.acc_cyc = 0;
        return r;
    endfunction

    // Waits for in_ready and presents one operation. Returns just after the accept edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic icin, input bit track);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("issue_wait_in_ready", {63'd0, in_ready}, 64'd1);
            return;
        end
        a        = ia;
        b        = ib;
        sub      = isub;
        cin      = icin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e         = model(ia, ib, isub, icin);
        e.acc_cyc = cyc;
        if (track) exp_q.push_back(e);
        // Scramble the inputs so that any late sampling of them is detected.
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        cin      = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: checks latency on the rising edge of out_valid, and the result on the handshake.
    logic prev_ov   = 1'b0;
    bit   ready_chk = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_ov   = 1'b0;
            ready_chk = 1'b0;
        end else begin
            if (ready_chk) begin
                check("in_ready_after_handshake", {63'd0, in_ready}, 64'd1);
                ready_chk = 1'b0;
            end
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0)
                    check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                else
                    check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(NCHUNK));
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("y",    64'(y),    64'(e.y));
                check("cout", 64'(cout), 64'(e.cout));
                check("ovf",  64'(ovf),  64'(e.ovf));
                check("zero", 64'(zero), 64'(e.zero));
                ready_chk = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    logic [W-1:0] corner [4];
    logic [W-1:0] ra, rb;
    exp_t         bp;

    initial begin
        corner[0] = 16'h0000;
        corner[1] = 16'h7FFF;
        corner[2] = 16'h8000;
        corner[3] = 16'hFFFF;

        reset    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;
        cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_y",         64'(y),             64'd0);
        check("rst_cout",      {63'd0, cout},      64'd0);
        check("rst_ovf",       {63'd0, ovf},       64'd0);
        check("rst_zero",      {63'd0, zero},      64'd0);

        // Directed add and subtract cases.
        issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1);
        issue(16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1);
        issue(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
        issue(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
        issue(16'h0010, 16'h0003, 1'b1, 1'b1, 1'b1);
        drain();

        // Backpressure: hold the result in DONE while the inputs toggle.
        ready_mode = 1;
        @(posedge clk);
        issue(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 1'b1);
        bp = model(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check("bp_out_valid_rise", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = W'($urandom);
            b        = W'($urandom);
            @(negedge clk);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready",  {63'd0, in_ready},  64'd0);
            check("bp_y",         64'(y),             64'(bp.y));
            check("bp_flags",     {61'd0, cout, ovf, zero}, {61'd0, bp.cout, bp.ovf, bp.zero});
        end
        in_valid   = 1'b0;
        ready_mode = 0;
        drain();

        // Reset during RUN discards the operation in flight.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  {63'd0, in_ready},  64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_out_valid_hold", {63'd0, out_valid}, 64'd0);
        end
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();

        // Random operations with corner operands and random out_ready.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rb = corner[$urandom_range(0, 3)];
            issue(ra, rb, 1'($urandom), 1'($urandom), 1'b1);
        end
        drain();
        ready_mode = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
